serial_magnitude_comparator: RTL and testbench
==============================================

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new comparison.
REQ-005 The block SHALL have port musteri1, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port musteri2, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in COMPARE or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-009 The block SHALL have port kirmizi, output, 1 bit: result A > B.
REQ-010 The block SHALL have port yesil, output, 1 bit: result A < B.
REQ-011 The block SHALL have port sari, output, 1 bit: result A = B.
REQ-012 The block SHALL have port cmp_count, output, 8 bits: number of completed comparisons.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COMPARE, DONE.
REQ-014 In IDLE, start=1 at edge E0 SHALL capture musteri1/musteri2 into internal registers, load bit index to WIDTH-1, and enter COMPARE.
REQ-015 start SHALL be ignored in COMPARE and DONE; operand inputs SHALL be ignored except at the capture edge.
REQ-016 In COMPARE, each edge SHALL examine one captured bit pair at the current index, MSB first.
REQ-017 If the bits differ, the FSM SHALL write the result (A bit 1 -> kirmizi, else yesil) and enter DONE at that edge.
REQ-018 If the bits are equal and the index is 0, the FSM SHALL write sari and enter DONE; otherwise it SHALL decrement the index and remain in COMPARE.
REQ-019 Latency: done SHALL be high in the cycle following edge E0+n, where n = WIDTH-j and j is the highest differing bit index; n = WIDTH when the operands are equal.
REQ-020 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE unconditionally.
REQ-021 A start in the same cycle as done SHALL be ignored; the earliest accepted restart is one cycle after done.
REQ-022 kirmizi, yesil and sari SHALL be registered, one-hot after the first result, and SHALL hold their value until the next result is written.
REQ-023 cmp_count SHALL increment by 1 on each entry to DONE and SHALL saturate at 255.

Reset
REQ-024 While rst_n=0, the FSM SHALL be in IDLE and busy, done, kirmizi, yesil, sari and cmp_count SHALL all be 0.
REQ-025 Reset asserted mid-comparison SHALL abort the comparison immediately, with no done pulse and no result written.
REQ-026 After rst_n deassertion, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Configuration
REQ-027 Macro SIGNED_CMP_EN defined SHALL make operands two's complement: at bit WIDTH-1 only, a differing pair SHALL set yesil when the A bit is 1 and kirmizi when the B bit is 1.
REQ-028 Macro SIGNED_CMP_EN undefined SHALL make all operands unsigned, with all bits treated per REQ-017.

Verification (WIDTH=8)
REQ-029 A=0x80, B=0x7F, start pulse -> done one cycle after E0+1; kirmizi=1 unsigned; yesil=1 with SIGNED_CMP_EN.
REQ-030 A=0x5A, B=0x5A -> done after E0+8; sari=1; cmp_count increments 0->1.
REQ-031 A=0x12, B=0x13 -> done after E0+8 (j=0); yesil=1; outputs held after done until the next result.
REQ-032 start held high for 20 cycles with A=0x01, B=0x00 -> restart only from IDLE; a new done every 10 cycles; no start accepted in the done cycle.
REQ-033 rst_n pulsed low at E0+3 of an A=0x03, B=0x02 comparison -> no done; all outputs 0; a fresh start gives kirmizi after E0+8.
REQ-034 300 back-to-back comparisons -> cmp_count stops at 255.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial, MSB-first magnitude comparator with registered one-hot result flags.
// Define SIGNED_CMP_EN to treat operands as two's complement (sign bit decides inversely); default is unsigned.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] musteri1,
    input  logic [WIDTH-1:0] musteri2,
    output logic             busy,
    output logic             done,
    output logic             kirmizi,
    output logic             yesil,
    output logic             sari,
    output logic [7:0]       cmp_count
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB = IW'(WIDTH - 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic             a_bit, b_bit, a_wins;

    assign a_bit   = a_q[idx_q];
    assign b_bit   = b_q[idx_q];
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef SIGNED_CMP_EN
    assign a_wins  = (idx_q == MSB) ? b_bit : a_bit;
`else
    assign a_wins  = a_bit;
`endif

    // Next-state logic: capture in IDLE, scan one bit pair per cycle in COMPARE, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = musteri1;
                    b_d     = musteri2;
                    idx_d   = MSB;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_bit != b_bit) begin
                    res_d   = a_wins ? 3'b100 : 3'b010;
                    cnt_d   = cnt_inc;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = 3'b001;
                    cnt_d   = cnt_inc;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any comparison in flight and clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign kirmizi   = res_q[2];
    assign yesil     = res_q[1];
    assign sari      = res_q[0];
    assign cmp_count = cnt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: vector table plus hand sequences, results checked through a scoreboard queue.
module tb_serial_magnitude_comparator;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   res;
        int           n;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;

    logic         clk, rst_n, start;
    logic [W-1:0] musteri1, musteri2;
    logic         busy, done, kirmizi, yesil, sari;
    logic [7:0]   cmp_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cnt_exp = 0;
    exp_t q[$];
    vec_t vecs[12];

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .musteri1(musteri1), .musteri2(musteri2),
        .busy(busy), .done(done), .kirmizi(kirmizi), .yesil(yesil), .sari(sari),
        .cmp_count(cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
        logic gt, lt;
`ifdef SIGNED_CMP_EN
        gt = $signed(a) > $signed(b);
        lt = $signed(a) < $signed(b);
`else
        gt = a > b;
        lt = a < b;
`endif
        return {gt, lt, a == b};
    endfunction

    function automatic int model_n(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int j = W - 1; j >= 0; j--)
            if (a[j] != b[j]) return W - j;
        return W;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                chk("result", 32'({kirmizi, yesil, sari}), 32'(e.res));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic push_exp(input logic [2:0] res, input int n, input int e0);
        exp_t e;
        e.res = res;
        e.cyc = e0 + n;
        q.push_back(e);
        cnt_exp = (cnt_exp == 255) ? 255 : cnt_exp + 1;
    endtask

    task automatic issue(input vec_t v);
        push_exp(v.res, v.n, cyc + 1);
        start = 1'b1;
        musteri1 = v.a;
        musteri2 = v.b;
        tick();
        start = 1'b0;
        musteri1 = 8'($urandom);
        musteri2 = 8'($urandom);
        chk("busy_compare", 32'(busy), 32'd1);
        drain();
        tick();
        chk("hold_result", 32'({kirmizi, yesil, sari}), 32'(v.res));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("count", 32'(cmp_count), 32'(cnt_exp));
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        v.res = model_res(a, b);
        v.n = model_n(a, b);
        return v;
    endfunction

    initial begin
        vec_t v;
        vecs[0]  = mk(8'h80, 8'h7F);
        vecs[1]  = mk(8'h5A, 8'h5A);
        vecs[2]  = mk(8'h12, 8'h13);
        vecs[3]  = mk(8'h00, 8'hFF);
        vecs[4]  = mk(8'hFF, 8'h00);
        vecs[5]  = mk(8'hFF, 8'hFF);
        vecs[6]  = mk(8'h00, 8'h00);
        vecs[7]  = mk(8'h01, 8'h00);
        vecs[8]  = mk(8'h7F, 8'h80);
        vecs[9]  = mk(8'h40, 8'h3F);
        vecs[10] = mk(8'hC3, 8'hC7);
        vecs[11] = mk(8'($urandom), 8'($urandom));

        rst_n = 1'b0;
        start = 1'b0;
        musteri1 = '0;
        musteri2 = '0;
        tick();
        start = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({kirmizi, yesil, sari}), 32'd0);
        chk("rst_count", 32'(cmp_count), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Operand-dependent latency and flags; first start right after reset release.
        chk("vec0_latency_one", 32'(vecs[0].n), 32'd1);
        for (int i = 0; i < 12; i++) issue(vecs[i]);

        // start held high 20 cycles: accepted only from IDLE, a done every 10 cycles.
        v = mk(8'h01, 8'h00);
        push_exp(v.res, v.n, cyc + 1);
        push_exp(v.res, v.n, cyc + 11);
        start = 1'b1;
        musteri1 = v.a;
        musteri2 = v.b;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b0;
        drain();
        tick();
        chk("held_start_idle", 32'(busy), 32'd0);
        chk("held_start_count", 32'(cmp_count), 32'(cnt_exp));

        // Reset at E0+3 aborts without a done pulse or result.
        start = 1'b1;
        musteri1 = 8'h03;
        musteri2 = 8'h02;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({kirmizi, yesil, sari}), 32'd0);
        chk("abort_count", 32'(cmp_count), 32'd0);
        cnt_exp = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        v = mk(8'h03, 8'h02);
        chk("fresh_exp_kirmizi", 32'(v.res), 32'b100);
        issue(v);

        // Saturation of the completed-comparison counter.
        for (int i = 0; i < 300; i++) issue(mk(8'h80, 8'h00));
        chk("count_saturated", 32'(cmp_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
